// File: rtl/addsub_unit_pkg.sv
// Shared opcode encodings and the registered flag bundle for the add/sub unit.
package addsub_unit_pkg;

  localparam logic [2:0] OP_SUB     = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_SATSUB  = 3'd2;
  localparam logic [2:0] OP_SATADD  = 3'd3;
  localparam logic [2:0] OP_ACCLOAD = 3'd4;
  localparam logic [2:0] OP_ACCSUB  = 3'd5;
  localparam logic [2:0] OP_ACCADD  = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic err;
  } flags_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational arithmetic for one beat: (a, b, op) -> result and flags.
// For accumulator ops b carries ACC, so ACCSUB computes b - a.
module addsub_core
  import addsub_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif_ab;
  logic [WIDTH:0] dif_ba;
  logic           ovf_add;
  logic           ovf_ab;
  logic           ovf_ba;

  // Bit WIDTH of each result is the carry-out or the borrow.
  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif_ab = {1'b0, a} - {1'b0, b};
  assign dif_ba = {1'b0, b} - {1'b0, a};

  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign ovf_ab  = (a[MSB] != b[MSB]) && (dif_ab[MSB] != a[MSB]);
  assign ovf_ba  = (a[MSB] != b[MSB]) && (dif_ba[MSB] != b[MSB]);

  always_comb begin
    out   = '0;
    flags = '0;
    case (op)
      OP_SUB: begin
        out            = dif_ab[MSB:0];
        flags.carry    = dif_ab[WIDTH];
        flags.overflow = ovf_ab;
      end
      OP_ADD: begin
        out            = sum[MSB:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = ovf_add;
      end
      OP_SATSUB: begin
        out            = dif_ab[WIDTH] ? '0 : dif_ab[MSB:0];
        flags.carry    = dif_ab[WIDTH];
        flags.overflow = ovf_ab;
      end
      OP_SATADD: begin
        out            = sum[WIDTH] ? '1 : sum[MSB:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = ovf_add;
      end
      OP_ACCLOAD: begin
        out = a;
      end
      OP_ACCSUB: begin
        out            = dif_ba[MSB:0];
        flags.carry    = dif_ba[WIDTH];
        flags.overflow = ovf_ba;
      end
      OP_ACCADD: begin
        out            = sum[MSB:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = ovf_add;
      end
      default: begin
        flags.err = 1'b1;
      end
    endcase
    flags.zero = (out == '0);
  end

endmodule

// File: rtl/addsub_unit.sv
// Registered add/sub/accumulate stage; latency 1, one result register.
// Backpressure: io_in_ready drops while an undelivered result is held and the consumer is stalled.
module addsub_unit
  import addsub_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in1,
  input  logic [WIDTH-1:0] io_in2,
  input  logic [2:0]       io_op,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_carry,
  output logic             io_overflow,
  output logic             io_zero,
  output logic             io_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic             acc_src;
  logic             acc_wr;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_out;
  flags_t           core_flags;

  assign io_in_ready = !reset && (!out_valid_q || io_out_ready);
  assign accept      = io_in_valid && io_in_ready;
  assign acc_src     = (io_op == OP_ACCSUB) || (io_op == OP_ACCADD);
  assign acc_wr      = acc_src || (io_op == OP_ACCLOAD);
  assign core_b      = acc_src ? acc_q : io_in2;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (io_in1),
    .b     (core_b),
    .op    (io_op),
    .out   (core_out),
    .flags (core_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = core_out;
      flags_d     = core_flags;
      if (acc_wr) begin
        acc_d = core_out;
      end
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out       = out_q;
  assign io_carry     = flags_q.carry;
  assign io_overflow  = flags_q.overflow;
  assign io_zero      = flags_q.zero;
  assign io_err       = flags_q.err;

endmodule

// File: tb/tb_addsub_unit.sv
// Bench for addsub_unit at WIDTH=8: vector table streamed through a scoreboard,
// plus hand sequences for backpressure, reserved opcode and mid-operation reset.
module tb_addsub_unit;
  import addsub_unit_pkg::*;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       v;
    logic       z;
    logic       e;
  } exp_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       x;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in1;
  logic [7:0] io_in2;
  logic [2:0] io_op;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out;
  logic       io_carry;
  logic       io_overflow;
  logic       io_zero;
  logic       io_err;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t tbl[17];

  addsub_unit #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in1       (io_in1),
    .io_in2       (io_in2),
    .io_op        (io_op),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out       (io_out),
    .io_carry     (io_carry),
    .io_overflow  (io_overflow),
    .io_zero      (io_zero),
    .io_err       (io_err)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] o, input logic c, input logic v,
                              input logic z, input logic e);
    vec_t t;
    t.op = op; t.a = a; t.b = b;
    t.x.out = o; t.x.c = c; t.x.v = v; t.x.z = z; t.x.e = e;
    return t;
  endfunction

  function automatic exp_t mkx(input logic [7:0] o, input logic c, input logic v,
                               input logic z, input logic e);
    exp_t t;
    t.out = o; t.c = c; t.v = v; t.z = z; t.e = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // Offers one beat and waits (bounded) until it is accepted; call #1 after a posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input exp_t x, input bit track);
    int guard = 0;
    io_in_valid = 1'b1; io_op = op; io_in1 = a; io_in2 = b;
    while (!io_in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    tests++;
    if (guard >= 50) begin
      fails++;
      $display("FAIL send_timeout: op=%0d ready=%b, want ready=1", op, io_in_ready);
    end
    if (track) exp_q.push_back(x);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic drain();
    io_out_ready = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b1;
    io_in1 = '0; io_in2 = '0; io_op = OP_SUB;

    // Scoreboard consumer: a result is taken on the edge after a negedge with valid && ready.
    fork
      forever begin
        @(negedge clock);
        if (!reset && io_out_valid && io_out_ready) begin
          exp_t act, want;
          act = {io_out, io_carry, io_overflow, io_zero, io_err};
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got out=%h, want no result", io_out);
          end else begin
            want = exp_q.pop_front();
            tests++;
            if (act !== want)
              begin
                fails++;
                $display("FAIL result: got out=%h c=%b v=%b z=%b e=%b, want out=%h c=%b v=%b z=%b e=%b",
                         act.out, act.c, act.v, act.z, act.e,
                         want.out, want.c, want.v, want.z, want.e);
              end
          end
        end
      end
    join_none

    tbl[0]  = mk(OP_SUB,     8'h05, 8'h07, 8'hFE, 1, 0, 0, 0);
    tbl[1]  = mk(OP_ADD,     8'h7F, 8'h01, 8'h80, 0, 1, 0, 0);
    tbl[2]  = mk(OP_SATSUB,  8'h05, 8'h07, 8'h00, 1, 0, 1, 0);
    tbl[3]  = mk(OP_SATADD,  8'hC8, 8'h64, 8'hFF, 1, 0, 0, 0);
    tbl[4]  = mk(OP_ACCLOAD, 8'h0A, 8'h33, 8'h0A, 0, 0, 0, 0);
    tbl[5]  = mk(OP_ACCSUB,  8'h03, 8'h44, 8'h07, 0, 0, 0, 0);
    tbl[6]  = mk(OP_ACCADD,  8'hFA, 8'h55, 8'h01, 1, 0, 0, 0);
    tbl[7]  = mk(OP_SUB,     8'h80, 8'h01, 8'h7F, 0, 1, 0, 0);
    tbl[8]  = mk(OP_ADD,     8'hFF, 8'h01, 8'h00, 1, 0, 1, 0);
    tbl[9]  = mk(OP_SATSUB,  8'h09, 8'h09, 8'h00, 0, 0, 1, 0);
    tbl[10] = mk(OP_SATADD,  8'h7F, 8'h7F, 8'hFE, 0, 1, 0, 0);
    tbl[11] = mk(OP_RSVD,    8'h55, 8'hAA, 8'h00, 0, 0, 1, 1);
    tbl[12] = mk(OP_ACCADD,  8'h00, 8'h12, 8'h01, 0, 0, 0, 0);
    tbl[13] = mk(OP_ACCSUB,  8'h02, 8'h00, 8'hFF, 1, 0, 0, 0);
    tbl[14] = mk(OP_ACCLOAD, 8'h80, 8'h00, 8'h80, 0, 0, 0, 0);
    tbl[15] = mk(OP_ACCSUB,  8'h01, 8'h00, 8'h7F, 0, 1, 0, 0);
    tbl[16] = mk(OP_ACCADD,  8'h01, 8'h00, 8'h80, 0, 1, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready_low", {63'd0, io_in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, io_out_valid}, 64'd0);
    chk("rst_out", {56'd0, io_out}, 64'd0);
    chk("rst_flags", {60'd0, io_carry, io_overflow, io_zero, io_err}, 64'd0);
    chk("rst_in_ready_high", {63'd0, io_in_ready}, 64'd1);
    @(posedge clock); #1;

    // Back-to-back stream; ACC ends at 0x80.
    foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].x, 1'b1);
    drain();

    // Backpressure: hold ADD 1+2 while a competing ACCLOAD is offered.
    io_out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, mkx(8'h03, 0, 0, 0, 0), 1'b1);
    io_in_valid = 1'b1; io_op = OP_ACCLOAD; io_in1 = 8'h99; io_in2 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      chk("hold_out", {56'd0, io_out}, 64'h03);
      chk("hold_valid", {63'd0, io_out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, io_in_ready}, 64'd0);
      @(posedge clock); #1;
    end
    io_out_ready = 1'b1;
    #1;
    chk("passthru_in_ready", {63'd0, io_in_ready}, 64'd1);
    send(OP_ACCADD, 8'h00, 8'h00, mkx(8'h80, 0, 0, 0, 0), 1'b1);
    drain();

    // Reset with a pending result and ACC=0x20 discards both.
    io_out_ready = 1'b0;
    send(OP_ACCLOAD, 8'h20, 8'h00, mkx(8'h20, 0, 0, 0, 0), 1'b0);
    chk("pre_rst_valid", {63'd0, io_out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, io_in_ready}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_valid", {63'd0, io_out_valid}, 64'd0);
    chk("post_rst_out", {56'd0, io_out}, 64'd0);
    chk("post_rst_flags", {60'd0, io_carry, io_overflow, io_zero, io_err}, 64'd0);
    chk("post_rst_in_ready", {63'd0, io_in_ready}, 64'd1);
    io_out_ready = 1'b1;
    send(OP_ACCADD, 8'h00, 8'h00, mkx(8'h00, 0, 0, 1, 0), 1'b1);
    drain();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
